// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I-subset datapath (lw, sw, add, sub, and, or, addi, beq).
// Sequences one instruction at a time from the IR fields and drives every datapath enable and mux select.
module multicycle_ctrl #(
    parameter logic [3:0] ALU_ADD = 4'b0010,
    parameter logic [3:0] ALU_SUB = 4'b0110,
    parameter logic [3:0] ALU_AND = 4'b0000,
    parameter logic [3:0] ALU_OR  = 4'b0001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic [3:0] alu_ctl,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    // state     | meaning
    // FETCH     | read instruction at PC into IR
    // DECODE    | ALUOut <= PC + imm (branch target), A/B latched
    // MEM_ADDR  | ALUOut <= A + imm (load/store address)
    // MEM_READ  | MDR <= mem[ALUOut]
    // LW_WB     | rd <= MDR, PC += 4
    // MEM_WRITE | mem[ALUOut] <= B, PC += 4
    // R_EXEC    | ALUOut <= A op B
    // I_EXEC    | ALUOut <= A + imm
    // ALU_WB    | rd <= ALUOut, PC += 4
    // BEQ       | compare A - B, PC <= ALUOut when equal
    // BR_NT     | branch not taken, PC += 4
    // NOP_INC   | unsupported encoding, flag it and skip, PC += 4
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_LW_WB     = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_I_EXEC    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BEQ       = 4'd9,
        S_BR_NT     = 4'd10,
        S_NOP_INC   = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t     state_q;
    logic [3:0] r_fn;
    logic       is_lw;
    logic       is_sw;
    logic       is_rtype;
    logic       is_addi;
    logic       is_beq;
    logic       pc_inc;

    assign r_fn     = {funct7_5, funct3};
    assign is_lw    = (opcode == OP_LOAD)   && (funct3 == 3'b010);
    assign is_sw    = (opcode == OP_STORE)  && (funct3 == 3'b010);
    assign is_addi  = (opcode == OP_IMM)    && (funct3 == 3'b000);
    assign is_beq   = (opcode == OP_BRANCH) && (funct3 == 3'b000);
    assign is_rtype = (opcode == OP_RTYPE) &&
                      (r_fn == 4'b0000 || r_fn == 4'b1000 || r_fn == 4'b0111 || r_fn == 4'b0110);

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:    state_q <= S_DECODE;
                S_DECODE: begin
                    if (is_lw || is_sw) state_q <= S_MEM_ADDR;
                    else if (is_rtype)  state_q <= S_R_EXEC;
                    else if (is_addi)   state_q <= S_I_EXEC;
                    else if (is_beq)    state_q <= S_BEQ;
                    else                state_q <= S_NOP_INC;
                end
                S_MEM_ADDR: state_q <= is_lw ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ: state_q <= S_LW_WB;
                S_R_EXEC:   state_q <= S_ALU_WB;
                S_I_EXEC:   state_q <= S_ALU_WB;
                S_BEQ:      state_q <= zero ? S_FETCH : S_BR_NT;
                default:    state_q <= S_FETCH;
            endcase
        end
    end

    // Outputs decode the current state so FETCH controls are live in the first
    // cycle after reset and the BEQ PC load can follow zero within the cycle.
    always_comb begin
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        pc_source  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        reg_write  = 1'b0;
        alu_ctl    = ALU_ADD;
        instr_done = 1'b0;
        illegal    = 1'b0;
        pc_inc     = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    ir_write  = 1'b1;
                    alu_src_b = 2'b01;
                end
                S_DECODE:   alu_src_b = 2'b10;
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_READ: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                S_LW_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    pc_inc     = 1'b1;
                end
                S_MEM_WRITE: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                    pc_inc    = 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    case (r_fn)
                        4'b1000: alu_ctl = ALU_SUB;
                        4'b0111: alu_ctl = ALU_AND;
                        4'b0110: alu_ctl = ALU_OR;
                        default: alu_ctl = ALU_ADD;
                    endcase
                end
                S_I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_ALU_WB: begin
                    reg_write = 1'b1;
                    pc_inc    = 1'b1;
                end
                S_BEQ: begin
                    alu_src_a  = 1'b1;
                    alu_ctl    = ALU_SUB;
                    pc_source  = 1'b1;
                    pc_write   = zero;
                    instr_done = zero;
                end
                S_BR_NT:    pc_inc = 1'b1;
                S_NOP_INC: begin
                    illegal = 1'b1;
                    pc_inc  = 1'b1;
                end
                default: ;
            endcase
            if (pc_inc) begin
                alu_src_a  = 1'b0;
                alu_src_b  = 2'b01;
                alu_ctl    = ALU_ADD;
                pc_source  = 1'b0;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a behavioural datapath runs small programs under the
// controller; expected per-instruction results queue up and are matched on instr_done.
module tb_multicycle_ctrl;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg;
    logic       pc_source, alu_src_a, reg_write, instr_done, illegal;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctl;
    logic [3:0] state;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .pc_write(pc_write), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
        .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .reg_write(reg_write), .alu_ctl(alu_ctl), .instr_done(instr_done),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // Behavioural datapath
    logic [31:0] pc, ir, mdr, a_q, b_q, aluout;
    logic [31:0] mem [64];
    logic [31:0] regs [32];
    logic [31:0] img_mem [64];
    logic [31:0] img_regs [32];
    logic        load_req = 1'b0;
    logic [31:0] imm, alu_a, alu_b, alu_res, maddr;

    assign opcode   = ir[6:0];
    assign funct3   = ir[14:12];
    assign funct7_5 = ir[30];
    assign zero     = (alu_res == 32'd0);

    always_comb begin
        case (ir[6:0])
            7'b0100011: imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            7'b1100011: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            default:    imm = {{20{ir[31]}}, ir[31:20]};
        endcase
        alu_a = alu_src_a ? a_q : pc;
        case (alu_src_b)
            2'b00:   alu_b = b_q;
            2'b01:   alu_b = 32'd4;
            default: alu_b = imm;
        endcase
        case (alu_ctl)
            ALU_SUB: alu_res = alu_a - alu_b;
            ALU_AND: alu_res = alu_a & alu_b;
            ALU_OR:  alu_res = alu_a | alu_b;
            default: alu_res = alu_a + alu_b;
        endcase
        maddr = iord ? aluout : pc;
    end

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 64; i++) mem[i] <= img_mem[i];
            for (int i = 0; i < 32; i++) regs[i] <= img_regs[i];
        end else begin
            if (mem_write) mem[maddr[7:2]] <= b_q;
            if (reg_write && ir[11:7] != 5'd0) regs[ir[11:7]] <= mem_to_reg ? mdr : aluout;
        end
        if (ir_write) ir <= mem[maddr[7:2]];
        if (mem_read && iord) mdr <= mem[maddr[7:2]];
        a_q    <= regs[ir[19:15]];
        b_q    <= regs[ir[24:20]];
        aluout <= alu_res;
        if (reset)         pc <= 32'd0;
        else if (pc_write) pc <= pc_source ? aluout : alu_res;
    end

    // Scoreboard
    typedef struct {
        int          lat;
        logic [19:0] path;
        logic [31:0] pc;
        bit          is_mem;
        int          idx;
        logic [31:0] val;
        int          il;
        int          mw;
        int          rw;
        logic [3:0]  aluctl;
        logic [31:0] maddr;
    } exp_t;

    exp_t sb[$];
    exp_t pexp;
    bit   pend = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc, n_il, n_mw, n_rw;
    logic [19:0] path;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input int lat, input logic [19:0] p, input logic [31:0] npc,
                            input bit is_mem, input int idx, input logic [31:0] val,
                            input int il, input int mw, input int rw,
                            input logic [3:0] actl, input logic [31:0] ma);
        exp_t e;
        e.lat = lat; e.path = p; e.pc = npc; e.is_mem = is_mem; e.idx = idx; e.val = val;
        e.il = il; e.mw = mw; e.rw = rw; e.aluctl = actl; e.maddr = ma;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            cyc = 0; path = '0; n_il = 0; n_mw = 0; n_rw = 0; pend = 1'b0;
        end else begin
            if (pend) begin
                chk("pc_after", pc, pexp.pc);
                if (pexp.is_mem) chk("mem_after", mem[pexp.idx], pexp.val);
                else             chk("reg_after", regs[pexp.idx], pexp.val);
                pend = 1'b0;
            end
            if (state == 4'd0) begin
                cyc = 1; path = '0; n_il = 0; n_mw = 0; n_rw = 0;
            end else begin
                cyc++;
                path = {path[15:0], state};
            end
            n_il += int'(illegal);
            n_mw += int'(mem_write);
            n_rw += int'(reg_write);
            chk("inv_rd_wr", 32'(mem_read & mem_write), 32'd0);
            chk("inv_irw_fetch", 32'(ir_write & (state != 4'd0)), 32'd0);
            chk("inv_rw_pcsrc", 32'(reg_write & pc_source), 32'd0);
            if (sb.size() > 0) begin
                if (mem_write) chk("mw_addr", maddr, sb[0].maddr);
                if (state == 4'd6) chk("r_alu_ctl", 32'(alu_ctl), 32'(sb[0].aluctl));
            end
            if (instr_done) begin
                if (sb.size() == 0) begin
                    chk("extra_done", 32'(instr_done), 32'd0);
                end else begin
                    pexp = sb.pop_front();
                    chk("latency", cyc, pexp.lat);
                    chk("state_path", 32'(path), 32'(pexp.path));
                    chk("illegal_cnt", n_il, pexp.il);
                    chk("mem_write_cnt", n_mw, pexp.mw);
                    chk("reg_write_cnt", n_rw, pexp.rw);
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic clear_images();
        for (int i = 0; i < 64; i++) img_mem[i] = 32'd0;
        for (int i = 0; i < 32; i++) img_regs[i] = 32'd0;
    endtask

    task automatic load_and_release();
        load_req = 1'b1;
        @(posedge clk); #2;
        load_req = 1'b0;
        reset = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 200 && (sb.size() != 0 || pend); c++) begin
            @(posedge clk); #2;
        end
        if (sb.size() != 0 || pend) chk({tag, "_timeout"}, sb.size(), 0);
        reset = 1'b1;
        @(posedge clk); #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Group 1: reset behaviour, addi/beq program
        clear_images();
        img_mem[0] = 32'h00400293;   // addi x5,x0,4
        img_mem[1] = 32'hFFF00293;   // addi x5,x0,-1
        img_mem[2] = 32'h00028263;   // beq x5,x0,+4
        img_mem[3] = 32'hFE000CE3;   // beq x0,x0,-8
        load_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            chk("rst_pc_write", 32'(pc_write), 32'd0);
            chk("rst_ir_write", 32'(ir_write), 32'd0);
            chk("rst_state", 32'(state), 32'd0);
        end
        load_req = 1'b0;
        push_exp(4, 20'h00178, 32'd4,  0, 5, 32'd4,        0, 0, 1, ALU_ADD, 32'd0);
        push_exp(4, 20'h00178, 32'd8,  0, 5, 32'hFFFFFFFF, 0, 0, 1, ALU_ADD, 32'd0);
        push_exp(4, 20'h0019A, 32'd12, 0, 5, 32'hFFFFFFFF, 0, 0, 0, ALU_ADD, 32'd0);
        push_exp(3, 20'h00019, 32'd4,  0, 5, 32'hFFFFFFFF, 0, 0, 0, ALU_ADD, 32'd0);
        reset = 1'b0;
        #1;
        chk("first_state", 32'(state), 32'd0);
        chk("first_ir_write", 32'(ir_write), 32'd1);
        chk("first_mem_read", 32'(mem_read), 32'd1);
        drain("prog1");

        // Group 2: sw then lw through address 0x80
        clear_images();
        img_mem[0] = 32'h08502023;   // sw x5,0x80(x0)
        img_mem[1] = 32'h08002303;   // lw x6,0x80(x0)
        img_regs[5] = 32'hDEADBEEF;
        push_exp(4, 20'h00125, 32'd4, 1, 32, 32'hDEADBEEF, 0, 1, 0, ALU_ADD, 32'h80);
        push_exp(5, 20'h01234, 32'd8, 0, 6,  32'hDEADBEEF, 0, 0, 1, ALU_ADD, 32'h80);
        load_and_release();
        drain("swlw");

        // Group 3: R-type add/sub/and/or
        clear_images();
        img_mem[0] = 32'h002081B3;   // add x3,x1,x2
        img_mem[1] = 32'h40208233;   // sub x4,x1,x2
        img_mem[2] = 32'h0020F3B3;   // and x7,x1,x2
        img_mem[3] = 32'h0020E433;   // or  x8,x1,x2
        img_regs[1] = 32'hC;
        img_regs[2] = 32'hA;
        push_exp(4, 20'h00168, 32'd4,  0, 3, 32'h16, 0, 0, 1, ALU_ADD, 32'd0);
        push_exp(4, 20'h00168, 32'd8,  0, 4, 32'h2,  0, 0, 1, ALU_SUB, 32'd0);
        push_exp(4, 20'h00168, 32'd12, 0, 7, 32'h8,  0, 0, 1, ALU_AND, 32'd0);
        push_exp(4, 20'h00168, 32'd16, 0, 8, 32'hE,  0, 0, 1, ALU_OR,  32'd0);
        load_and_release();
        drain("rtype");

        // Group 4: unsupported encodings
        clear_images();
        img_mem[0] = 32'h000002B7;   // lui x5,0
        img_mem[1] = 32'h002094B3;   // sll x9,x1,x2
        img_regs[1] = 32'hC;
        img_regs[2] = 32'hA;
        img_regs[5] = 32'h55;
        push_exp(3, 20'h0001B, 32'd4, 0, 5, 32'h55, 1, 0, 0, ALU_ADD, 32'd0);
        push_exp(3, 20'h0001B, 32'd8, 0, 9, 32'h0,  1, 0, 0, ALU_ADD, 32'd0);
        load_and_release();
        drain("illegal");

        // Group 5: reset lands in MEM_WRITE
        clear_images();
        img_mem[0]  = 32'h08502023;  // sw x5,0x80(x0)
        img_mem[32] = 32'h12345678;
        img_regs[5] = 32'hDEADBEEF;
        load_and_release();
        for (int c = 0; c < 20 && state != 4'd5; c++) begin
            @(posedge clk); #2;
        end
        chk("reach_mem_write", 32'(state), 32'd5);
        reset = 1'b1;
        #1;
        chk("rst_mw_gate", 32'(mem_write), 32'd0);
        chk("rst_pcw_gate", 32'(pc_write), 32'd0);
        @(posedge clk); #2;
        chk("rst_state_after", 32'(state), 32'd0);
        chk("rst_pc_after", pc, 32'd0);
        chk("rst_mem_kept", mem[32], 32'h12345678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
